// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the block-organised instruction memory.
// The cache fetches whole 128-bit blocks made of four 32-bit words.
package instr_mem_pkg;

    localparam int BLOCK_W         = 128;
    localparam int WORD_W          = 32;
    localparam int WORDS_PER_BLOCK = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    function automatic int unsigned word_lane(input logic [1:0] k);
        return WORD_W * int'(k);
    endfunction

endpackage

// File: rtl/instr_mem_array.sv
// Block storage with one 32-bit word write port and one combinational
// 128-bit block read port.
module instr_mem_array
    import instr_mem_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic                clk,
    input  logic                we,
    input  logic [ADDR_W+1:0]   waddr,
    input  logic [WORD_W-1:0]   wdata,
    input  logic [ADDR_W-1:0]   raddr,
    output logic [BLOCK_W-1:0]  rdata
);

    logic [BLOCK_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr[ADDR_W+1:2]][word_lane(waddr[1:0]) +: WORD_W] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_block_memory.sv
// Instruction memory behind the I-cache: returns one block per miss after
// a fixed latency, with a registered busywait and a word program-load port.
module instr_block_memory
    import instr_mem_pkg::*;
#(
    parameter int BLOCK_ADDR_W = 6,
    parameter int LATENCY      = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     read,
    input  logic [BLOCK_ADDR_W-1:0]  address,
    output logic [BLOCK_W-1:0]       readdata,
    output logic                     busywait,
    input  logic                     prog_we,
    input  logic [BLOCK_ADDR_W+1:0]  prog_addr,
    input  logic [WORD_W-1:0]        prog_wdata
);

    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    state_t                    state;
    state_t                    state_nxt;
    logic [7:0]                cnt;
    logic [7:0]                cnt_nxt;
    logic                      busy_nxt;
    logic [BLOCK_W-1:0]        data_nxt;
    logic [BLOCK_ADDR_W-1:0]   req_addr;
    logic [BLOCK_ADDR_W-1:0]   req_nxt;
    logic [BLOCK_W-1:0]        block;

    instr_mem_array #(
        .ADDR_W (BLOCK_ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (prog_we),
        .waddr (prog_addr),
        .wdata (prog_wdata),
        .raddr (req_addr),
        .rdata (block)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy_nxt  = busywait;
        data_nxt  = readdata;
        req_nxt   = req_addr;
        unique case (state)
            IDLE: begin
                if (read) begin
                    req_nxt   = address;
                    busy_nxt  = 1'b1;
                    cnt_nxt   = CNT_INIT;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (cnt != 8'd0) begin
                    cnt_nxt = cnt - 8'd1;
                end else begin
                    data_nxt  = block;
                    busy_nxt  = 1'b0;
                    state_nxt = DONE;
                end
            end
            // One dead cycle so a still-high read from the cache is not re-accepted
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busywait <= 1'b0;
            readdata <= '0;
            cnt      <= '0;
        end else begin
            state    <= state_nxt;
            busywait <= busy_nxt;
            readdata <= data_nxt;
            cnt      <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        req_addr <= req_nxt;
    end

endmodule

// File: tb/tb_instr_block_memory.sv
// Bench for instr_block_memory: directed table, corner sequences and
// randomized requests against a word-array reference model.
module tb_instr_block_memory;
    import instr_mem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         read4, read1;
    logic [5:0]   address4, address1;
    logic [127:0] readdata4, readdata1;
    logic         busywait4, busywait1;
    logic         prog_we4, prog_we1;
    logic [7:0]   prog_addr4, prog_addr1;
    logic [31:0]  prog_wdata4, prog_wdata1;

    instr_block_memory #(.BLOCK_ADDR_W(6), .LATENCY(4)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .read       (read4),
        .address    (address4),
        .readdata   (readdata4),
        .busywait   (busywait4),
        .prog_we    (prog_we4),
        .prog_addr  (prog_addr4),
        .prog_wdata (prog_wdata4)
    );

    instr_block_memory #(.BLOCK_ADDR_W(6), .LATENCY(1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .read       (read1),
        .address    (address1),
        .readdata   (readdata1),
        .busywait   (busywait1),
        .prog_we    (prog_we1),
        .prog_addr  (prog_addr1),
        .prog_wdata (prog_wdata1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model4 [256];
    logic [31:0] model1 [256];

    localparam logic [127:0] B5 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] B9 = 128'h99999999_aaaaaaaa_bbbbbbbb_cccccccc;

    typedef struct {
        logic [5:0]   blk;
        int           we_edge;
        logic [31:0]  wdata;
        bit           change;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge clk);
        if (prog_we4) model4[prog_addr4] = prog_wdata4;
        if (prog_we1) model1[prog_addr1] = prog_wdata1;
        #1;
    endtask

    function automatic logic [127:0] blk4(input logic [5:0] b);
        return {model4[{b, 2'd3}], model4[{b, 2'd2}],
                model4[{b, 2'd1}], model4[{b, 2'd0}]};
    endfunction

    function automatic logic [127:0] blk1(input logic [5:0] b);
        return {model1[{b, 2'd3}], model1[{b, 2'd2}],
                model1[{b, 2'd1}], model1[{b, 2'd0}]};
    endfunction

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check_blk(input string name, input logic [127:0] got,
                             input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic write4(input logic [7:0] a, input logic [31:0] d);
        prog_we4 = 1'b1; prog_addr4 = a; prog_wdata4 = d;
        tick();
        prog_we4 = 1'b0;
    endtask

    task automatic write1(input logic [7:0] a, input logic [31:0] d);
        prog_we1 = 1'b1; prog_addr1 = a; prog_wdata1 = d;
        tick();
        prog_we1 = 1'b0;
    endtask

    initial begin
        logic [127:0] b5v;
        logic [127:0] b9v;
        logic [127:0] exp;
        logic [5:0]   b;

        b5v = B5;
        b9v = B9;
        vecs[0] = '{6'd5, -1, 32'h0, 1'b0, B5};
        vecs[1] = '{6'd5, 3, 32'hDEADBEEF, 1'b0, {b5v[127:32], 32'hDEADBEEF}};
        vecs[2] = '{6'd5, 4, 32'hDEADBEEF, 1'b0, B5};
        vecs[3] = '{6'd5, -1, 32'h0, 1'b1, B5};
        vecs[4] = '{6'd9, -1, 32'h0, 1'b0, B9};

        reset = 1'b1;
        read4 = 1'b0; address4 = '0; prog_we4 = 1'b0; prog_addr4 = '0; prog_wdata4 = '0;
        read1 = 1'b0; address1 = '0; prog_we1 = 1'b0; prog_addr1 = '0; prog_wdata1 = '0;
        tick();
        tick();
        check_bit("reset_busy4", busywait4, 1'b0);
        check_blk("reset_data4", readdata4, '0);
        check_bit("reset_busy1", busywait1, 1'b0);
        check_blk("reset_data1", readdata1, '0);
        reset = 1'b0;

        for (int i = 0; i < 256; i++) write4(8'(i), $urandom);

        // Directed table: load-then-read, write race, mid-request change, hold
        for (int i = 0; i < 5; i++) begin
            for (int w = 0; w < 4; w++) begin
                write4({6'd5, 2'(w)}, b5v[32*w +: 32]);
                write4({6'd9, 2'(w)}, b9v[32*w +: 32]);
            end
            read4 = 1'b1;
            address4 = vecs[i].blk;
            check_bit("busy_at_rise", busywait4, 1'b0);
            tick();
            check_bit("busy_after_accept", busywait4, 1'b1);
            for (int e = 1; e <= 4; e++) begin
                if (vecs[i].change && e == 2) begin
                    address4 = 6'd9;
                    read4 = 1'b0;
                end
                if (vecs[i].we_edge == e) begin
                    prog_we4 = 1'b1; prog_addr4 = 8'h14; prog_wdata4 = vecs[i].wdata;
                end
                tick();
                prog_we4 = 1'b0;
                if (e < 4) begin
                    check_bit("busy_inflight", busywait4, 1'b1);
                end else begin
                    check_bit("busy_complete", busywait4, 1'b0);
                    check_blk("table_data", readdata4, vecs[i].exp);
                end
            end
            read4 = 1'b1;
            tick();
            check_bit("done_hold_busy", busywait4, 1'b0);
            read4 = 1'b0;
            tick();
            check_bit("no_retrigger", busywait4, 1'b0);
            check_blk("data_held", readdata4, vecs[i].exp);
        end

        // Reset aborts an in-flight request; storage survives
        read4 = 1'b1; address4 = 6'd5;
        tick();
        read4 = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_bit("abort_busy", busywait4, 1'b0);
        check_blk("abort_data", readdata4, '0);
        read4 = 1'b1; address4 = 6'd9;
        tick();
        read4 = 1'b0;
        repeat (3) tick();
        check_bit("post_reset_busy", busywait4, 1'b1);
        tick();
        check_bit("post_reset_done", busywait4, 1'b0);
        check_blk("post_reset_data", readdata4, blk4(6'd9));
        tick();

        // Randomized requests with concurrent program-load writes
        for (int it = 0; it < 30; it++) begin
            b = 6'($urandom_range(0, 63));
            read4 = 1'b1; address4 = b;
            tick();
            exp = '0;
            for (int e = 1; e <= 4; e++) begin
                read4 = 1'($urandom);
                address4 = 6'($urandom);
                prog_we4 = 1'($urandom);
                prog_addr4 = ($urandom % 2 == 0) ? {b, 2'($urandom)} : 8'($urandom);
                prog_wdata4 = $urandom;
                if (e == 4) exp = blk4(b);
                tick();
            end
            prog_we4 = 1'b0;
            check_bit("rand_busy", busywait4, 1'b0);
            check_blk("rand_data", readdata4, exp);
            read4 = 1'($urandom);
            tick();
            read4 = 1'b0;
            tick();
            check_bit("rand_idle", busywait4, 1'b0);
        end

        // LATENCY=1 back-to-back with read held high
        for (int i = 0; i < 8; i++) write1(8'(i), $urandom);
        read1 = 1'b1; address1 = 6'd0;
        check_bit("l1_rise", busywait1, 1'b0);
        tick();
        address1 = 6'd1;
        check_bit("l1_e0_busy", busywait1, 1'b1);
        tick();
        check_bit("l1_e1_busy", busywait1, 1'b0);
        check_blk("l1_e1_data", readdata1, blk1(6'd0));
        tick();
        check_bit("l1_e2_busy", busywait1, 1'b0);
        tick();
        check_bit("l1_e3_busy", busywait1, 1'b1);
        tick();
        check_bit("l1_e4_busy", busywait1, 1'b0);
        check_blk("l1_e4_data", readdata1, blk1(6'd1));
        read1 = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_block_memory.md
Name: instr_block_memory

Overview:
- Block-organised instruction memory that sits directly downstream of the instruction cache.
- Serves one 128-bit (4-word) block per miss request after a fixed, parameterised cycle latency.
- Uses a registered busywait handshake whose timing matches the cache controller's MEM_READ / CACHE_UPDATE sequencing.
- Provides a word-wide program-load port so benches and boot logic can preload code.

Parameters:
- BLOCK_ADDR_W, 6: block address width; the memory holds 2^6 = 64 blocks (1 KiB).
- WORDS_PER_BLOCK, 4: 32-bit words per block; fixed, with BLOCK_W = 128.
- LATENCY, 4: cycles from request acceptance to data return; legal range 1..255.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- read  in  1  block read request, level-sensitive, from the cache controller.
- address  in  6  block address, {tag, index} from the cache.
- readdata  out  128  returned block; word k occupies bits [32k+31:32k].
- busywait  out  1  registered; high while a request is in flight.
- prog_we  in  1  program-load word write enable.
- prog_addr  in  8  word address {block[5:0], word[1:0]}.
- prog_wdata  in  32  word to write.

Behaviour:
- Reset (synchronous, active-high) sets state to IDLE, busywait to 0, readdata to 0 and cnt to 0.
- Reset does not clear the storage array.
- Reset during BUSY aborts the request; no data is returned.
- FSM states:
  - IDLE: at a rising edge with read=1, latch address into req_addr, set busywait<=1, set cnt<=LATENCY-1, and go to BUSY.
  - BUSY:
    - If cnt!=0, decrement cnt.
    - If cnt==0, set readdata<=array[req_addr], set busywait<=0, and go to DONE.
  - DONE: ignore read, hold readdata, and go to IDLE unconditionally. This prevents re-triggering while the cache is still in its MEM_READ→CACHE_UPDATE transition with read high.
- Latency: request sampled at edge N; readdata valid and busywait low after edge N+LATENCY.
- The next request can be accepted no earlier than edge N+LATENCY+2.
- busywait is 0 in the cycle read first rises; it goes high only after the acceptance edge. The cache checks busywait only from MEM_READ onward, so this is compliant.
- Changes on address or read during BUSY are ignored. A read dropped mid-request does not abort; the request completes normally.
- readdata holds its last value until the next completion; there is no X or clear between requests.
- Program-load writes:
  - prog_we=1 writes array word prog_addr at the edge, in any state.
  - A write at an edge strictly before the completion edge is visible in the returned block.
  - A write at the completion edge itself is not visible; the old value is returned.
- Address widths are exact, so there are no out-of-range cases.
- LATENCY=1 gives IDLE→BUSY (cnt=0)→completion on the next edge.

Decomposition:
- Package instr_mem_pkg holds:
  - BLOCK_W = 128, WORD_W = 32, WORDS_PER_BLOCK;
  - state enum {IDLE, BUSY, DONE}, 2-bit;
  - helper function word_lane(k) returning the bit offset.
- Sub-module instr_mem_array: 64×128 storage with one 32-bit word write port (lane select from prog_addr[1:0]) and one combinational 128-bit block read port.
- The top level contains the FSM, cnt, req_addr and output registers.

Test Plan:
- Load-then-read:
  - Stimulus: preload block 5 with words 0x11111111, 0x22222222, 0x33333333, 0x44444444; then drive read=1, address=5 at edge 0 (LATENCY=4).
  - Required: busywait=1 over edges 1..3; at edge 4 busywait=0 and readdata=0x44444444_33333333_22222222_11111111.
- Cache-style hold:
  - Stimulus: keep read=1 for one cycle after completion.
  - Required: DONE ignores it; no second request; busywait stays 0; state returns to IDLE.
- Mid-request change:
  - Stimulus: switch address 5→9 and drop read at edge 2.
  - Required: block 5 is still returned at edge 4.
- Write race:
  - Stimulus: prog_we to word 0x14 (block 5, word 0) with 0xDEADBEEF, once at edge 3 and once at edge 4, in separate runs.
  - Required: the edge-3 write appears in bits [31:0]; the edge-4 write returns old 0x11111111.
- Reset mid-operation:
  - Stimulus: assert reset at edge 2 of a request.
  - Required: busywait=0 and readdata=0 next edge; array contents intact; a new request afterwards returns correct data.
- LATENCY=1 back-to-back:
  - Stimulus: continuous requests to blocks 0 then 1.
  - Required: completions at edges 1 and 4; readdata correct each time.
